// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM states and 7-segment decode shared by cpu_multicycle
package cpu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00, OP_LW = 2'b01, OP_SW = 2'b10, OP_J = 2'b11;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    // active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter returning value mod 100 as two BCD digits
module bin2bcd_seq #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic              done,
    output logic [3:0]        tens,
    output logic [3:0]        ones
);
    localparam int ND = DATA_W * 3 / 10 + 1;
    localparam int BW = 4 * ND;
    localparam int PW = $clog2(DATA_W + 2);
    logic [BW-1:0] bcd, adj;
    logic [DATA_W-1:0] sh;
    logic [PW-1:0] ph;
    always_comb begin
        adj = bcd;
        for (int i = 0; i < ND; i++)
            adj[4*i +: 4] = (bcd[4*i +: 4] > 4'd4) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    // ph 1..DATA_W shift, DATA_W+1 keeps only the two low digits (mod 100)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= '0;
            bcd <= '0;
            sh <= '0;
            done <= 1'b0;
            tens <= '0;
            ones <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                ph <= PW'(1);
                bcd <= '0;
                sh <= value;
            end else if (ph == PW'(DATA_W + 1)) begin
                ph <= '0;
                done <= 1'b1;
                tens <= bcd[7:4];
                ones <= bcd[3:0];
            end else if (ph != '0) begin
                ph <= ph + PW'(1);
                {bcd, sh} <= {adj, sh} << 1;
            end
        end
    end
endmodule

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: parametrised multi-cycle add/lw/sw/j CPU with run/step control and 2-digit display
module cpu_multicycle #(
    parameter int DATA_W   = 8,
    parameter int REG_AW   = 2,
    parameter int ADDR_W   = 8,
    parameter int DMEM_AW  = 5,
    parameter int CLK_DIV  = 25_000_000,
    parameter int DISP_REG = 2,
    localparam int INSN_W  = 2 + 3 * REG_AW
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic [INSN_W-1:0] instruction,
    input  logic              run,
    input  logic              step,
    output logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic [6:0]        bcd10,
    output logic [6:0]        bcd1
);
    import cpu_pkg::*;
    localparam int DEPTH = 2 ** DMEM_AW;
    localparam int NREG = 2 ** REG_AW;
    localparam int JW = INSN_W - 2;
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [REG_AW-1:0] DR = REG_AW'(DISP_REG);
    state_t state;
    logic [CW-1:0] cnt;
    logic tick, req, done;
    logic [INSN_W-1:0] ir;
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] a, b, res, md;
    logic [DMEM_AW-1:0] ea;
    logic [ADDR_W-1:0] tgt;
    logic [3:0] tens, ones;
    logic [1:0] op;
    logic [REG_AW-1:0] rs, rt, rd;
    assign op = ir[INSN_W-1 -: 2];
    assign rs = ir[3*REG_AW-1 -: REG_AW];
    assign rt = ir[2*REG_AW-1 -: REG_AW];
    assign rd = ir[REG_AW-1:0];
    assign tick = cnt == CW'(CLK_DIV - 1);
    assign busy = state != S_IDLE;
    // req starts at 1 so the display converts once right after reset release
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            address <= '0;
            cnt <= '0;
            req <= 1'b1;
            ir <= '0;
            a <= '0;
            b <= '0;
            res <= '0;
            md <= '0;
            ea <= '0;
            tgt <= '0;
            bcd10 <= seg7(4'd0);
            bcd1 <= seg7(4'd0);
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            req <= state == S_WB;
            if (done) begin
                bcd10 <= seg7(tens);
                bcd1 <= seg7(ones);
            end
            case (state)
                S_IDLE: if (run ? tick : step) state <= S_FETCH;
                S_FETCH: begin
                    ir <= instruction;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a <= regs[rs];
                    b <= regs[rt];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res <= a + b;
                    ea <= DMEM_AW'(a) + DMEM_AW'(rd);
                    tgt <= address + ADDR_W'(1) + {{(ADDR_W-JW){ir[JW-1]}}, ir[JW-1:0]};
                    state <= (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (op == OP_SW) mem[ea] <= b;
                    md <= mem[ea];
                    state <= S_WB;
                end
                S_WB: begin
                    if (op == OP_ADD) regs[rd] <= res;
                    if (op == OP_LW) regs[rt] <= md;
                    address <= (op == OP_J) ? tgt : address + ADDR_W'(1);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    bin2bcd_seq #(.DATA_W(DATA_W)) u_bcd (
        .clk(clk50),
        .rst_n(reset),
        .start(req),
        .value(regs[DR]),
        .done(done),
        .tens(tens),
        .ones(ones)
    );
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed program with a completion scoreboard for cpu_multicycle
module tb_cpu_multicycle;
    logic clk50 = 1'b0, reset = 1'b0, run = 1'b0, step = 1'b0;
    logic [7:0] instruction, address;
    logic busy;
    logic [6:0] bcd10, bcd1;
    logic [7:0] rom [256];
    int tests = 0, fails = 0, blen = 0;
    typedef struct { int pc; int lat; int t; int o; } exp_t;
    exp_t exp_q[$];
    exp_t me;
    localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    // {pc after, busy cycles, tens, ones} for ROM[3..13]
    localparam int T4 [11][4] = '{'{4,5,0,1}, '{5,4,0,1}, '{6,4,0,1}, '{7,4,0,1}, '{8,5,2,5}, '{9,4,5,0},
                                  '{10,4,0,0}, '{11,4,0,0}, '{12,5,0,0}, '{13,4,0,0}, '{14,4,4,4}};

    assign instruction = rom[address];

    cpu_multicycle #(.CLK_DIV(8)) dut (
        .clk50(clk50), .reset(reset), .instruction(instruction), .run(run), .step(step),
        .address(address), .busy(busy), .bcd10(bcd10), .bcd1(bcd1)
    );

    always #10 clk50 = ~clk50;

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic wait_busy(input logic lvl, input string nm);
        int n = 0;
        while (busy !== lvl && n < 50) begin
            @(negedge clk50);
            n++;
        end
        chk(nm, int'(busy), int'(lvl));
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk50);
        step = 1'b0;
    endtask

    task automatic run_insn(input int pc, input int lat, input int t, input int o, input bit extra, input bit on_tick);
        exp_q.push_back('{pc, lat, t, o});
        if (on_tick) begin
            int n = 0;
            while (dut.tick !== 1'b1 && n < 20) begin
                @(negedge clk50);
                n++;
            end
        end
        pulse_step();
        wait_busy(1'b1, $sformatf("busy_rise_pc%0d", pc));
        if (extra) begin
            @(negedge clk50);
            pulse_step();
        end
        wait_busy(1'b0, $sformatf("busy_fall_pc%0d", pc));
        repeat (20) @(negedge clk50);
    endtask

    // monitor: every completed instruction pops one expectation
    initial begin
        forever begin
            @(negedge clk50);
            if (!reset) blen = 0;
            else if (busy) blen++;
            else if (blen != 0) begin
                if (exp_q.size() == 0) chk("extra_insn_pc", int'(address), -1);
                else begin
                    me = exp_q.pop_front();
                    chk($sformatf("pc_exp%0d", me.pc), int'(address), me.pc);
                    chk($sformatf("latency_pc%0d", me.pc), blen, me.lat);
                    blen = 0;
                    repeat (16) @(negedge clk50);
                    chk($sformatf("tens_pc%0d", me.pc), int'(bcd10), int'(SEG[me.t]));
                    chk($sformatf("ones_pc%0d", me.pc), int'(bcd1), int'(SEG[me.o]));
                end
                blen = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        repeat (3) @(negedge clk50);
        chk("rst_address", int'(address), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tens", int'(bcd10), int'(SEG[0]));
        chk("rst_ones", int'(bcd1), int'(SEG[0]));
        reset = 1'b1;
        repeat (5) @(negedge clk50);
        pulse_step();
        repeat (2) @(negedge clk50);
        chk("busy_in_exec", int'(busy), 1);
        reset = 1'b0;
        #1;
        chk("abort_address", int'(address), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_tens", int'(bcd10), int'(SEG[0]));
        chk("abort_ones", int'(bcd1), int'(SEG[0]));
        for (int i = 0; i < 4; i++) chk($sformatf("abort_r%0d", i), int'(dut.regs[i]), 0);
        repeat (3) @(negedge clk50);
        reset = 1'b1;
        repeat (5) @(negedge clk50);
        rom[0] = 8'h49; rom[1] = 8'hC1; rom[3] = 8'h4F; rom[4] = 8'h3F; rom[5] = 8'h3F;
        rom[6] = 8'h3F; rom[7] = 8'h79; rom[8] = 8'h2A; rom[9] = 8'h2A; rom[10] = 8'h29;
        rom[11] = 8'h4C; rom[12] = 8'h18; rom[13] = 8'h0E; rom[14] = 8'h22; rom[15] = 8'h22;
        rom[16] = 8'hEE; rom[255] = 8'h2B;
        exp_q.push_back('{1, 5, 0, 1});
        run = 1'b1;
        wait_busy(1'b1, "run_start");
        run = 1'b0;
        wait_busy(1'b0, "run_done");
        repeat (20) @(negedge clk50);
        chk("lw_r2", int'(dut.regs[2]), 1);
        run_insn(3, 4, 0, 1, 1'b0, 1'b0);
        chk("j_mem1", int'(dut.mem[1]), 1);
        for (int i = 0; i < 11; i++) run_insn(T4[i][0], T4[i][1], T4[i][2], T4[i][3], 1'b0, 1'b0);
        chk("add_wrap_r0", int'(dut.regs[0]), 44);
        run_insn(15, 4, 8, 8, 1'b1, 1'b0);
        chk("step_while_busy_pc", int'(address), 15);
        run_insn(16, 4, 3, 2, 1'b0, 1'b1);
        repeat (30) @(negedge clk50);
        chk("ticks_stepped_pc", int'(address), 16);
        chk("ticks_stepped_busy", int'(busy), 0);
        rom[0] = 8'h3F; rom[1] = 8'h3F; rom[2] = 8'hB1; rom[3] = 8'h79;
        run_insn(255, 4, 3, 2, 1'b0, 1'b0);
        run_insn(0, 4, 3, 2, 1'b0, 1'b0);
        run_insn(1, 4, 3, 2, 1'b0, 1'b0);
        run_insn(2, 4, 3, 2, 1'b0, 1'b0);
        chk("r3_base", int'(dut.regs[3]), 32);
        run_insn(3, 5, 3, 2, 1'b0, 1'b0);
        chk("sw_wrap_mem1", int'(dut.mem[1]), 44);
        run_insn(4, 5, 4, 4, 1'b0, 1'b0);
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk50);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
